// File: rtl/fft2_sched_pkg.sv
// Shared types and constants for the 2-D convolution job scheduler.
package fft2_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FFT_GO,
        ST_FFT_BUSY,
        ST_FFT_WAIT,
        ST_MUL_GO,
        ST_MUL_WAIT,
        ST_DONE,
        ST_ERR
    } sched_state_e;

    typedef enum logic [1:0] {
        PH_IMG,
        PH_KER,
        PH_MUL,
        PH_INV
    } phase_e;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_DIM    = 2'd1;
    localparam logic [1:0] ERR_FFT_TO = 2'd2;
    localparam logic [1:0] ERR_MUL_TO = 2'd3;

    localparam logic [1:0] BANK_0 = 2'd0;
    localparam logic [1:0] BANK_1 = 2'd1;
    localparam logic [1:0] BANK_2 = 2'd2;
    localparam logic [1:0] BANK_3 = 2'd3;

endpackage

// File: rtl/sched_watchdog.sv
// Per-phase watchdog: counts enabled cycles since the last clear and
// flags expiry once the count reaches TIMEOUT_CYCLES.
module sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES));

    // Count up while enabled; saturate at the limit so expiry stays asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fft2_conv_sched.sv
// Convolution job scheduler: FFT2(image), FFT2(kernel), pointwise multiply,
// inverse FFT2, with per-phase bank selection and a watchdog on every wait.
module fft2_conv_sched
    import fft2_sched_pkg::*;
#(
    parameter int FFT_SIZE       = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int LOG2_BITS      = $clog2($clog2(FFT_SIZE) + 1)
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [LOG2_BITS-1:0]          cmd_log2w,
    input  logic [LOG2_BITS-1:0]          cmd_log2h,
    output logic                          fft_start,
    input  logic                          fft_ready,
    output logic                          fft_inverse,
    output logic [LOG2_BITS-1:0]          fft_log2w,
    output logic [LOG2_BITS-1:0]          fft_log2h,
    output logic [$clog2(FFT_SIZE)-1:0]   fft_width,
    output logic [$clog2(FFT_SIZE)-1:0]   fft_height,
    output logic [1:0]                    src_bank,
    output logic [1:0]                    dst_bank,
    output logic                          mul_start,
    input  logic                          mul_done,
    output logic                          job_done,
    output logic                          job_err,
    output logic [1:0]                    err_code
);
    localparam int DIM_W    = $clog2(FFT_SIZE);
    localparam int MAX_LOG2 = $clog2(FFT_SIZE);

    sched_state_e         state;
    sched_state_e         state_prev;
    phase_e               phase;
    logic [LOG2_BITS-1:0] lat_w;
    logic [LOG2_BITS-1:0] lat_h;
    logic                 dim_bad;
    logic                 wd_clr;
    logic                 wd_en;
    logic                 wd_expired;

    // (1 << l2) - 1, computed one bit wider so l2 == MAX_LOG2 does not wrap.
    function automatic logic [DIM_W-1:0] dim_minus_one(input logic [LOG2_BITS-1:0] l2);
        logic [DIM_W:0] full;
        full = (DIM_W + 1)'(1) << l2;
        return DIM_W'(full - (DIM_W + 1)'(1));
    endfunction

    assign dim_bad = (lat_w > LOG2_BITS'(MAX_LOG2)) || (lat_h > LOG2_BITS'(MAX_LOG2)) ||
                     (lat_w == '0) || (lat_h == '0);

    // The watchdog restarts on every state entry and only runs in wait states.
    assign wd_clr = (state != state_prev);
    assign wd_en  = (state == ST_FFT_GO) || (state == ST_FFT_BUSY) ||
                    (state == ST_FFT_WAIT) || (state == ST_MUL_WAIT);

    sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (pclk),
        .rst_n  (presetn),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    // Remember last cycle's state so a state entry can be detected.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_prev <= ST_IDLE;
        end else begin
            state_prev <= state;
        end
    end

    // Job sequencer with registered handshake, config and status outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= ST_IDLE;
            phase       <= PH_IMG;
            lat_w       <= '0;
            lat_h       <= '0;
            cmd_ready   <= 1'b1;
            fft_start   <= 1'b0;
            fft_inverse <= 1'b0;
            fft_log2w   <= '0;
            fft_log2h   <= '0;
            fft_width   <= '0;
            fft_height  <= '0;
            src_bank    <= BANK_0;
            dst_bank    <= BANK_0;
            mul_start   <= 1'b0;
            job_done    <= 1'b0;
            job_err     <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            fft_start <= 1'b0;
            mul_start <= 1'b0;
            job_done  <= 1'b0;
            job_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        lat_w     <= cmd_log2w;
                        lat_h     <= cmd_log2h;
                        err_code  <= ERR_NONE;
                        cmd_ready <= 1'b0;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (dim_bad) begin
                        job_err   <= 1'b1;
                        err_code  <= ERR_DIM;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        fft_log2w   <= lat_w;
                        fft_log2h   <= lat_h;
                        fft_width   <= dim_minus_one(lat_w);
                        fft_height  <= dim_minus_one(lat_h);
                        fft_inverse <= 1'b0;
                        src_bank    <= BANK_0;
                        dst_bank    <= BANK_2;
                        phase       <= PH_IMG;
                        state       <= ST_FFT_GO;
                    end
                end
                ST_FFT_GO: begin
                    if (wd_expired) begin
                        err_code <= ERR_FFT_TO;
                        state    <= ST_ERR;
                    end else if (fft_ready) begin
                        fft_start <= 1'b1;
                        state     <= ST_FFT_BUSY;
                    end
                end
                ST_FFT_BUSY: begin
                    if (wd_expired) begin
                        err_code <= ERR_FFT_TO;
                        state    <= ST_ERR;
                    end else if (!fft_ready) begin
                        state <= ST_FFT_WAIT;
                    end
                end
                ST_FFT_WAIT: begin
                    if (wd_expired) begin
                        err_code <= ERR_FFT_TO;
                        state    <= ST_ERR;
                    end else if (fft_ready) begin
                        case (phase)
                            PH_IMG: begin
                                phase    <= PH_KER;
                                src_bank <= BANK_1;
                                dst_bank <= BANK_3;
                                state    <= ST_FFT_GO;
                            end
                            PH_KER: begin
                                phase <= PH_MUL;
                                state <= ST_MUL_GO;
                            end
                            default: begin
                                job_done <= 1'b1;
                                state    <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_MUL_GO: begin
                    mul_start <= 1'b1;
                    state     <= ST_MUL_WAIT;
                end
                ST_MUL_WAIT: begin
                    if (wd_expired) begin
                        err_code <= ERR_MUL_TO;
                        state    <= ST_ERR;
                    end else if (mul_done) begin
                        phase       <= PH_INV;
                        src_bank    <= BANK_2;
                        dst_bank    <= BANK_0;
                        fft_inverse <= 1'b1;
                        state       <= ST_FFT_GO;
                    end
                end
                ST_DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_ERR: begin
                    job_err   <= 1'b1;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft2_conv_sched.sv
// Directed bench for fft2_conv_sched with behavioural fft2 and multiplier models.
module tb_fft2_conv_sched;
    localparam int FFT_SIZE = 16;
    localparam int TIMEOUT  = 100;
    localparam int LB       = 3;
    localparam int DW       = 4;

    logic          pclk      = 1'b0;
    logic          presetn   = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LB-1:0] cmd_log2w = '0;
    logic [LB-1:0] cmd_log2h = '0;
    logic          fft_start;
    logic          fft_ready;
    logic          fft_inverse;
    logic [LB-1:0] fft_log2w;
    logic [LB-1:0] fft_log2h;
    logic [DW-1:0] fft_width;
    logic [DW-1:0] fft_height;
    logic [1:0]    src_bank;
    logic [1:0]    dst_bank;
    logic          mul_start;
    logic          mul_done;
    logic          job_done;
    logic          job_err;
    logic [1:0]    err_code;

    logic mul_done_m;
    logic stray    = 1'b0;
    logic fft_hang = 1'b0;
    logic mul_hang = 1'b0;
    assign mul_done = mul_done_m | stray;

    fft2_conv_sched #(
        .FFT_SIZE      (FFT_SIZE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_log2w  (cmd_log2w),
        .cmd_log2h  (cmd_log2h),
        .fft_start  (fft_start),
        .fft_ready  (fft_ready),
        .fft_inverse(fft_inverse),
        .fft_log2w  (fft_log2w),
        .fft_log2h  (fft_log2h),
        .fft_width  (fft_width),
        .fft_height (fft_height),
        .src_bank   (src_bank),
        .dst_bank   (dst_bank),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .job_done   (job_done),
        .job_err    (job_err),
        .err_code   (err_code)
    );

    always #5 pclk = ~pclk;

    // fft2 core model: idle-high ready, 20 busy cycles after a start
    int fcnt;
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            fft_ready <= 1'b1;
            fcnt      <= 0;
        end else if (fft_start) begin
            fft_ready <= 1'b0;
            fcnt      <= 20;
        end else if (!fft_ready && !fft_hang) begin
            if (fcnt <= 1) fft_ready <= 1'b1;
            else fcnt <= fcnt - 1;
        end
    end

    // multiplier model: done pulse about 30 cycles after a start
    int   mcnt;
    logic mbusy;
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            mul_done_m <= 1'b0;
            mbusy      <= 1'b0;
            mcnt       <= 0;
        end else begin
            mul_done_m <= 1'b0;
            if (mul_start) begin
                mbusy <= 1'b1;
                mcnt  <= 30;
            end else if (mbusy && !mul_hang) begin
                if (mcnt <= 1) begin
                    mul_done_m <= 1'b1;
                    mbusy      <= 1'b0;
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
        end
    end

    // event monitor: counts pulses and timestamps them in cycles
    int   cyc = 0;
    int   n_acc = 0, n_start = 0, n_mul = 0, n_done = 0, n_err = 0, n_b2b = 0;
    int   acc_cyc = 0, last_evt = 0, last_start = 0, done_cyc = 0, rdy_cyc = 0;
    int   err_acc_lat = 0, err_start_lat = 0, mul_lat = 0, done_lat = 0;
    int   rec_acc_lat [64];
    int   rec_evt_lat [64];
    logic [1:0]    rec_src [64];
    logic [1:0]    rec_dst [64];
    logic          rec_inv [64];
    logic [DW-1:0] rec_w   [64];
    logic [DW-1:0] rec_h   [64];
    logic          rec_stb [64];
    logic          prev_ready = 1'b1, prev_start = 1'b0, prev_rdy = 1'b1, prev_inv = 1'b0;
    logic [1:0]    prev_src = '0, prev_dst = '0;
    logic [DW-1:0] prev_w = '0, prev_h = '0;

    always @(posedge pclk) begin
        if (cmd_valid && cmd_ready) begin
            n_acc   <= n_acc + 1;
            acc_cyc <= cyc;
        end
        if ((fft_ready && !prev_ready) || mul_done) last_evt <= cyc;
        if (fft_start) begin
            rec_acc_lat[n_start % 64] <= cyc - acc_cyc;
            rec_evt_lat[n_start % 64] <= cyc - last_evt;
            rec_src[n_start % 64]     <= src_bank;
            rec_dst[n_start % 64]     <= dst_bank;
            rec_inv[n_start % 64]     <= fft_inverse;
            rec_w[n_start % 64]       <= fft_width;
            rec_h[n_start % 64]       <= fft_height;
            rec_stb[n_start % 64]     <= (src_bank == prev_src) && (dst_bank == prev_dst) &&
                                         (fft_inverse == prev_inv) && (fft_width == prev_w) &&
                                         (fft_height == prev_h);
            last_start <= cyc;
            n_start    <= n_start + 1;
            if (prev_start) n_b2b <= n_b2b + 1;
        end
        if (mul_start) begin
            n_mul   <= n_mul + 1;
            mul_lat <= cyc - last_evt;
        end
        if (job_done) begin
            n_done   <= n_done + 1;
            done_lat <= cyc - last_evt;
            done_cyc <= cyc;
        end
        if (job_err) begin
            n_err         <= n_err + 1;
            err_acc_lat   <= cyc - acc_cyc;
            err_start_lat <= cyc - last_start;
        end
        if (cmd_ready && !prev_rdy) rdy_cyc <= cyc;
        prev_ready <= fft_ready;
        prev_start <= fft_start;
        prev_rdy   <= cmd_ready;
        prev_src   <= src_bank;
        prev_dst   <= dst_bank;
        prev_inv   <= fft_inverse;
        prev_w     <= fft_width;
        prev_h     <= fft_height;
        cyc        <= cyc + 1;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {7'd0, fft_start, fft_inverse, mul_start, job_done, job_err, err_code,
                src_bank, dst_bank, fft_log2w, fft_log2h, fft_width, fft_height};
    endfunction

    task automatic send(input int w, input int h);
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_log2w = LB'(w);
        cmd_log2h = LB'(h);
        @(negedge pclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc);
        int k;
        k = 0;
        while (!(job_done || job_err) && k < max_cyc) begin
            @(negedge pclk);
            k++;
        end
        cmd_valid = 1'b0;
        check_eq("job_end_seen", 32'(k < max_cyc), 1);
        repeat (3) @(negedge pclk);
    endtask

    int bs, bm, bd, be, ba, k;

    initial begin
        // reset state
        repeat (3) @(negedge pclk);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_outputs", out_vec(), 0);
        presetn = 1'b1;
        repeat (2) @(negedge pclk);
        check_eq("idle_cmd_ready", cmd_ready, 1);
        check_eq("idle_outputs", out_vec(), 0);

        // full job 16x16
        bs = n_start; bm = n_mul; bd = n_done; be = n_err;
        send(4, 4);
        wait_end(400);
        check_eq("j1_fft_starts", n_start - bs, 3);
        check_eq("j1_mul_starts", n_mul - bm, 1);
        check_eq("j1_done", n_done - bd, 1);
        check_eq("j1_err", n_err - be, 0);
        check_eq("j1_p0_banks", {rec_src[bs % 64], rec_dst[bs % 64], rec_inv[bs % 64]}, {2'd0, 2'd2, 1'b0});
        check_eq("j1_p1_banks", {rec_src[(bs + 1) % 64], rec_dst[(bs + 1) % 64], rec_inv[(bs + 1) % 64]}, {2'd1, 2'd3, 1'b0});
        check_eq("j1_p3_banks", {rec_src[(bs + 2) % 64], rec_dst[(bs + 2) % 64], rec_inv[(bs + 2) % 64]}, {2'd2, 2'd0, 1'b1});
        check_eq("j1_width", rec_w[bs % 64], 15);
        check_eq("j1_height", rec_h[bs % 64], 15);
        check_eq("j1_cfg_log2", {fft_log2w, fft_log2h}, {3'd4, 3'd4});
        check_eq("j1_accept_lat_2to3", 32'(rec_acc_lat[bs % 64] >= 2 && rec_acc_lat[bs % 64] <= 3), 1);
        check_eq("j1_p1_lat", rec_evt_lat[(bs + 1) % 64], 2);
        check_eq("j1_mul_lat", mul_lat, 2);
        check_eq("j1_p3_lat", rec_evt_lat[(bs + 2) % 64], 2);
        check_eq("j1_done_lat", done_lat, 1);
        check_eq("j1_ready_after_done", rdy_cyc - done_cyc, 1);
        for (int i = 0; i < 3; i++) check_eq("j1_cfg_stable", rec_stb[(bs + i) % 64], 1);
        check_eq("j1_err_code", err_code, 0);
        check_eq("j1_cmd_ready", cmd_ready, 1);

        // 8x4 job
        bs = n_start; bd = n_done;
        send(3, 2);
        wait_end(400);
        check_eq("j2_done", n_done - bd, 1);
        check_eq("j2_fft_starts", n_start - bs, 3);
        check_eq("j2_width", rec_w[bs % 64], 7);
        check_eq("j2_height", rec_h[bs % 64], 3);
        check_eq("j2_p3_width", rec_w[(bs + 2) % 64], 7);

        // rejected dimensions: too large, zero width, zero height
        for (int t = 0; t < 3; t++) begin
            bs = n_start; be = n_err;
            case (t)
                0: send(5, 4);
                1: send(0, 2);
                default: send(4, 0);
            endcase
            wait_end(20);
            check_eq("bad_err", n_err - be, 1);
            check_eq("bad_err_lat", err_acc_lat, 2);
            check_eq("bad_err_code", err_code, 1);
            check_eq("bad_no_start", n_start - bs, 0);
            check_eq("bad_cmd_ready", cmd_ready, 1);
        end

        // fft never completes
        bs = n_start; bd = n_done; be = n_err;
        fft_hang = 1'b1;
        send(4, 4);
        wait_end(300);
        check_eq("fto_err", n_err - be, 1);
        check_eq("fto_err_code", err_code, 2);
        check_eq("fto_lat_window", 32'(err_start_lat >= 100 && err_start_lat <= 110), 1);
        check_eq("fto_no_done", n_done - bd, 0);
        check_eq("fto_one_start", n_start - bs, 1);
        check_eq("fto_cmd_ready", cmd_ready, 1);
        fft_hang = 1'b0;
        repeat (30) @(negedge pclk);

        // multiplier never completes
        bs = n_start; bm = n_mul; be = n_err;
        mul_hang = 1'b1;
        send(2, 2);
        wait_end(400);
        check_eq("mto_err", n_err - be, 1);
        check_eq("mto_err_code", err_code, 3);
        check_eq("mto_starts", n_start - bs, 2);
        check_eq("mto_cmd_ready", cmd_ready, 1);
        mul_hang = 1'b0;
        repeat (40) @(negedge pclk);

        // cmd_valid held through a job plus a stray mul_done in P0
        bs = n_start; bm = n_mul; bd = n_done; be = n_err; ba = n_acc;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_log2w = 3'd4;
        cmd_log2h = 3'd4;
        k = 0;
        while (n_start == bs && k < 50) begin
            @(negedge pclk);
            k++;
        end
        check_eq("hold_p0_started", 32'(k < 50), 1);
        stray = 1'b1;
        @(negedge pclk);
        stray = 1'b0;
        wait_end(400);
        repeat (3) @(negedge pclk);
        check_eq("hold_accepts", n_acc - ba, 1);
        check_eq("hold_done", n_done - bd, 1);
        check_eq("hold_fft_starts", n_start - bs, 3);
        check_eq("hold_mul_starts", n_mul - bm, 1);
        check_eq("hold_err", n_err - be, 0);

        // reset during MUL_WAIT, then a clean job
        bm = n_mul;
        send(4, 4);
        k = 0;
        while (n_mul == bm && k < 200) begin
            @(negedge pclk);
            k++;
        end
        check_eq("rmul_reached", 32'(k < 200), 1);
        repeat (5) @(negedge pclk);
        check_eq("rmul_pre_banks", {src_bank, dst_bank}, {2'd1, 2'd3});
        bd = n_done; be = n_err;
        presetn = 1'b0;
        #1;
        check_eq("rmul_cmd_ready", cmd_ready, 1);
        check_eq("rmul_outputs", out_vec(), 0);
        @(negedge pclk);
        presetn = 1'b1;
        repeat (60) @(negedge pclk);
        check_eq("rmul_no_done", n_done - bd, 0);
        check_eq("rmul_no_err", n_err - be, 0);
        bs = n_start; bd = n_done;
        send(3, 3);
        wait_end(400);
        check_eq("rnew_done", n_done - bd, 1);
        check_eq("rnew_starts", n_start - bs, 3);
        check_eq("rnew_p3_banks", {rec_src[(bs + 2) % 64], rec_dst[(bs + 2) % 64], rec_inv[(bs + 2) % 64]}, {2'd2, 2'd0, 1'b1});
        check_eq("rnew_width", rec_w[bs % 64], 7);

        check_eq("no_back_to_back_start", n_b2b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/fft2_conv_sched.md
# fft2_conv_sched

Job scheduler for the 2-D convolution datapath. It accepts one convolution command (image and kernel dimensions as log2 values), then sequences the shared fft2 core and the pointwise complex multiplier: FFT2 of image, FFT2 of kernel, multiply, inverse FFT2. It drives the fft2 configuration and start lines, selects memory banks for each phase, and reports done or error per job. It sits between the top-level register file and the fft2 core / multiplier.

## Interface
- FFT_SIZE, 16: maximum dimension; power of two, 4..256.
- TIMEOUT_CYCLES, 65535: watchdog limit per phase, in cycles; 1..2^20-1.
- LOG2_BITS, derived = $clog2($clog2(FFT_SIZE)+1): width of log2 fields.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- presetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  scheduler idle; command accepted when cmd_valid && cmd_ready.
- cmd_log2w  in  LOG2_BITS  log2 of width.
- cmd_log2h  in  LOG2_BITS  log2 of height.
- fft_start  out  1  one-cycle start pulse to fft2 core.
- fft_ready  in  1  fft2 core idle.
- fft_inverse  out  1  0 = forward, 1 = inverse transform.
- fft_log2w, fft_log2h  out  LOG2_BITS  latched config.
- fft_width, fft_height  out  $clog2(FFT_SIZE)  dimension minus one.
- src_bank, dst_bank  out  2  memory bank select for fft2 read/write ports.
- mul_start  out  1  one-cycle start pulse to multiplier.
- mul_done  in  1  one-cycle multiplier completion pulse.
- job_done  out  1  one-cycle pulse: job finished OK.
- job_err  out  1  one-cycle pulse: job rejected or timed out.
- err_code  out  2  0 none, 1 bad dimension, 2 fft timeout, 3 mul timeout; held until next accept.

## Operation
- Command check on accept: 2^log2w > FFT_SIZE, 2^log2h > FFT_SIZE, or log2w = 0 or log2h = 0 → job_err pulse, err_code=1, stay IDLE; no fft_start issued.
- Phases, bank map (src→dst): P0 forward, bank 0→2 (image); P1 forward, 1→3 (kernel); P2 multiply, 2×3→2 (banks fixed inside multiplier); P3 inverse, 2→0.
- FSM states: IDLE → CHECK → FFT_GO → FFT_BUSY → FFT_WAIT → (next phase) … → MUL_GO → MUL_WAIT → FFT_GO(P3) … → DONE → IDLE; any timeout → ERR → IDLE.
- FFT_GO: wait until fft_ready=1, then pulse fft_start for 1 cycle. FFT_BUSY: wait for fft_ready=0 (acknowledge). FFT_WAIT: wait for fft_ready=1 (complete).
- Watchdog: a counter clears on every state entry and counts in FFT_GO, FFT_BUSY, FFT_WAIT, and MUL_WAIT. When it reaches TIMEOUT_CYCLES, go to ERR: err_code=2 for an fft state, 3 for MUL_WAIT.
- fft_width = (1<<log2w)-1, fft_height = (1<<log2h)-1. Computed once in CHECK from latched values.
- Config, bank, and inverse outputs change only in CHECK or between phases, never while fft2 is busy.
- cmd_valid while busy is ignored; cmd_ready=1 only in IDLE.
- mul_done outside MUL_WAIT is ignored.

## Timing
- Reset values: cmd_ready=1; fft_start, mul_start, job_done, job_err, fft_inverse = 0; all config, width, height, bank outputs = 0; err_code=0.
- Accept cycle → CHECK (1 cycle) → fft_start at the earliest 2 cycles after accept.
- fft_start is registered. It never asserts in two consecutive cycles. Config is stable from 1 cycle before fft_start.
- Phase transition after fft_ready rises: next fft_start or mul_start after exactly 2 cycles.
- job_done pulses 1 cycle after the P3 complete is detected. cmd_ready returns high in the cycle after job_done.
- Bad dimension: job_err pulses 2 cycles after accept.
- Asynchronous reset mid-job: all outputs return to reset values immediately. No done or err pulse is issued for the aborted job.

## Structure
- Package fft2_sched_pkg: state enum, phase enum (PH_IMG, PH_KER, PH_MUL, PH_INV), err_code constants, bank constants.
- Sub-module sched_watchdog: counter with clear, enable, and expired outputs; parameter TIMEOUT_CYCLES.

## Test plan
- log2w=4, log2h=4, FFT_SIZE=16; model fft2 with 20-cycle busy and mul with 30 cycles → fft_start ×3, mul_start ×1; banks (0,2), (1,3), (2,0) with inverse=1 on the third fft; fft_width=fft_height=15; job_done once.
- log2w=3, log2h=2 → fft_width=7, fft_height=3; one complete job.
- log2w=5 with FFT_SIZE=16 → job_err 2 cycles after accept, err_code=1, no fft_start.
- fft model never raises ready, TIMEOUT_CYCLES=100 → job_err about 100 cycles after the FFT_WAIT entry, err_code=2, cmd_ready=1 afterwards.
- cmd_valid held high during a job, plus a stray mul_done during P0 → neither has any effect; exactly one job_done.
- presetn asserted during MUL_WAIT → all outputs at reset values at once; a new command then runs a clean full job.
